// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core's Avalon-MM bus arbiter.
package mips_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [BE_W-1:0] BE_WORD = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    BUS_I,
    BUS_D,
    FAULT
  } bus_state_t;

  // Registered Avalon-MM command presented on the master port
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
  } avm_cmd_t;

  function automatic logic word_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mips_wait_timer.sv
// Counts consecutive stalled bus cycles; flags the cycle in which the limit is reached.
module mips_wait_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LAST_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_INT);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // TIMEOUT of zero disables expiry entirely
  assign expired_c = (TIMEOUT != 0) && (count_q == LAST);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-MM master between instruction fetch and data load/store,
// one transaction at a time, with alignment checks and a sticky stall timeout.
module mips_bus_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 1024,
  parameter bit          DATA_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [DATA_W-1:0] writedata,
  output logic [BE_W-1:0]   byteenable,
  input  logic [DATA_W-1:0] readdata,
  output logic              bus_fault
);

  bus_state_t        state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: most recent grant went to the data port
  avm_cmd_t          cmd_q, cmd_d;
  logic [DATA_W-1:0] i_rdata_d, d_rdata_d;
  logic              i_ack_d, i_err_d, d_ack_d, d_err_d, fault_d;
  logic              i_elig, d_elig, pick_d;
  logic              tmr_start, tmr_en, tmr_expired_c;

  mips_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (tmr_start),
    .en        (tmr_en),
    .expired_c (tmr_expired_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_d_q  <= ~DATA_FIRST;
      cmd_q     <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      bus_fault <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cmd_q     <= cmd_d;
      i_rdata   <= i_rdata_d;
      d_rdata   <= d_rdata_d;
      i_ack     <= i_ack_d;
      i_err     <= i_err_d;
      d_ack     <= d_ack_d;
      d_err     <= d_err_d;
      bus_fault <= fault_d;
    end
  end

  // A port in its ack cycle is ignored so a held req is never issued twice
  assign i_elig = i_req && !i_ack;
  assign d_elig = d_req && !d_ack;
  assign pick_d = d_elig && (!i_elig || !last_d_q);

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    cmd_d     = cmd_q;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    fault_d   = bus_fault;
    tmr_start = 1'b0;
    tmr_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_elig || d_elig) begin
          last_d_d = pick_d;
          if (pick_d) begin
            if (word_misaligned(d_addr[1:0]) || (d_be == '0)) begin
              d_ack_d = 1'b1;
              d_err_d = 1'b1;
            end else begin
              cmd_d.address    = d_addr;
              cmd_d.writedata  = d_wdata;
              cmd_d.byteenable = d_be;
              cmd_d.read       = !d_we;
              cmd_d.write      = d_we;
              tmr_start        = 1'b1;
              state_d          = BUS_D;
            end
          end else begin
            if (word_misaligned(i_addr[1:0])) begin
              i_ack_d = 1'b1;
              i_err_d = 1'b1;
            end else begin
              cmd_d.address    = i_addr;
              cmd_d.writedata  = '0;
              cmd_d.byteenable = BE_WORD;
              cmd_d.read       = 1'b1;
              cmd_d.write      = 1'b0;
              tmr_start        = 1'b1;
              state_d          = BUS_I;
            end
          end
        end
      end

      BUS_I, BUS_D: begin
        tmr_en = waitrequest;
        if (!waitrequest) begin
          cmd_d.read  = 1'b0;
          cmd_d.write = 1'b0;
          tmr_start   = 1'b1;
          state_d     = IDLE;
          if (state_q == BUS_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = readdata;
          end else begin
            d_ack_d = 1'b1;
            if (cmd_q.read) begin
              d_rdata_d = readdata;
            end
          end
        end else if (tmr_expired_c) begin
          cmd_d.read  = 1'b0;
          cmd_d.write = 1'b0;
          fault_d     = 1'b1;
          state_d     = FAULT;
        end
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign address    = cmd_q.address;
  assign writedata  = cmd_q.writedata;
  assign byteenable = cmd_q.byteenable;
  assign read       = cmd_q.read;
  assign write      = cmd_q.write;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: arbitration, wait states, alignment, reset, timeout.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        bus_fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.TIMEOUT(8), .DATA_FIRST(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_ack       (i_ack),
    .i_err       (i_err),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_be        (d_be),
    .d_rdata     (d_rdata),
    .d_ack       (d_ack),
    .d_err       (d_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata),
    .bus_fault   (bus_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    waitrequest = 1'b0; readdata = '0;
    repeat (2) tick();

    // Reset state
    check("rst_read",  32'(read),      32'd0);
    check("rst_write", 32'(write),     32'd0);
    check("rst_iack",  32'(i_ack),     32'd0);
    check("rst_dack",  32'(d_ack),     32'd0);
    check("rst_fault", 32'(bus_fault), 32'd0);
    check("rst_addr",  address,        32'd0);
    reset_n = 1'b1;
    tick();

    // Contention: data wins the first tie after reset, then fetch
    i_req = 1'b1; i_addr = 32'h0000_0400;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
    readdata = 32'h1111_2222;
    tick();
    check("c_write",  32'(write),      32'd1);
    check("c_read0",  32'(read),       32'd0);
    check("c_addr",   address,         32'h0000_1000);
    check("c_wdata",  writedata,       32'hDEAD_BEEF);
    check("c_be",     32'(byteenable), 32'h3);
    tick();
    check("c_dack",   32'(d_ack),      32'd1);
    check("c_derr",   32'(d_err),      32'd0);
    check("c_wdrop",  32'(write),      32'd0);
    check("c_iack0",  32'(i_ack),      32'd0);
    d_req = 1'b0;
    tick();
    check("c_iread",  32'(read),       32'd1);
    check("c_iaddr",  address,         32'h0000_0400);
    check("c_ibe",    32'(byteenable), 32'hF);
    check("c_dack0",  32'(d_ack),      32'd0);
    tick();
    check("c_iack",   32'(i_ack),      32'd1);
    check("c_irdata", i_rdata,         32'h1111_2222);
    check("c_drdata", d_rdata,         32'd0);
    i_req = 1'b0;
    tick();

    // Fetch, zero wait
    i_req = 1'b1; i_addr = 32'hBFC0_0000; readdata = 32'h2402_0005;
    tick();
    check("f_read",  32'(read),  32'd1);
    check("f_addr",  address,    32'hBFC0_0000);
    check("f_ack0",  32'(i_ack), 32'd0);
    tick();
    check("f_ack",   32'(i_ack), 32'd1);
    check("f_err",   32'(i_err), 32'd0);
    check("f_rdata", i_rdata,    32'h2402_0005);
    check("f_rdrop", 32'(read),  32'd0);
    i_req = 1'b0;
    tick();
    check("f_ackpulse", 32'(i_ack), 32'd0);

    // Wait states during a data read
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000; d_be = 4'hF;
    waitrequest = 1'b1; readdata = 32'hBAD0_BAD0;
    tick();
    check("w_read1", 32'(read), 32'd1);
    check("w_addr1", address,   32'h0000_2000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("w_read",  32'(read),  32'd1);
      check("w_addr",  address,    32'h0000_2000);
      check("w_dack0", 32'(d_ack), 32'd0);
    end
    waitrequest = 1'b0; readdata = 32'hCAFE_F00D;
    tick();
    check("w_dack",  32'(d_ack), 32'd1);
    check("w_rdata", d_rdata,    32'hCAFE_F00D);
    check("w_rdrop", 32'(read),  32'd0);
    d_req = 1'b0; readdata = 32'h0;
    tick();
    check("w_once",  32'(d_ack), 32'd0);
    check("w_hold",  d_rdata,    32'hCAFE_F00D);

    // Misaligned accesses and empty byte enables
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1002; d_be = 4'hF;
    tick();
    check("m_dack",  32'(d_ack), 32'd1);
    check("m_derr",  32'(d_err), 32'd1);
    check("m_write", 32'(write), 32'd0);
    check("m_read",  32'(read),  32'd0);
    d_req = 1'b0;
    tick();
    check("m_dack0", 32'(d_ack), 32'd0);
    d_req = 1'b1; d_addr = 32'h0000_1000; d_be = 4'h0;
    tick();
    check("m_be0err", 32'(d_err), 32'd1);
    check("m_be0wr",  32'(write), 32'd0);
    d_req = 1'b0;
    tick();
    i_req = 1'b1; i_addr = 32'h0000_0001;
    tick();
    check("m_iack",  32'(i_ack), 32'd1);
    check("m_ierr",  32'(i_err), 32'd1);
    check("m_iread", 32'(read),  32'd0);
    check("m_ihold", i_rdata,    32'h2402_0005);
    i_req = 1'b0;
    tick();

    // Reset mid-transaction
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_3000; d_wdata = 32'h1234_5678; d_be = 4'hF;
    waitrequest = 1'b1;
    tick();
    check("r_write", 32'(write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("r_async", 32'(write), 32'd0);
    d_req = 1'b0; waitrequest = 1'b0;
    tick();
    reset_n = 1'b1;
    check("r_noack", 32'(d_ack), 32'd0);
    tick();
    check("r_noack2", 32'(d_ack), 32'd0);
    i_req = 1'b1; i_addr = 32'h0000_0100; readdata = 32'h0F0F_0F0F;
    tick();
    check("r_fread", 32'(read), 32'd1);
    tick();
    check("r_fack",   32'(i_ack), 32'd1);
    check("r_frdata", i_rdata,    32'h0F0F_0F0F);
    i_req = 1'b0;
    tick();

    // Timeout after 8 stalled bus cycles, then absorbing fault
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000; d_be = 4'hF;
    waitrequest = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t_read",   32'(read),      32'd1);
      check("t_fault0", 32'(bus_fault), 32'd0);
    end
    tick();
    check("t_rdrop", 32'(read),      32'd0);
    check("t_fault", 32'(bus_fault), 32'd1);
    check("t_noack", 32'(d_ack),     32'd0);
    d_req = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_0200; waitrequest = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t_nogrant", 32'(read),      32'd0);
      check("t_noiack",  32'(i_ack),     32'd0);
      check("t_sticky",  32'(bus_fault), 32'd1);
    end
    i_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
